// File: rtl/debounce_toggle_gen_if.sv
// Button-side bundle of debounce_toggle_gen: raw button in, toggle pulse and
// debounced level out. The slave modport belongs to the debouncer.
interface debounce_toggle_gen_if;
  logic btn_in;
  logic T_out;
  logic btn_level;

  modport master (
    output btn_in,
    input  T_out,
    input  btn_level
  );

  modport slave (
    input  btn_in,
    output T_out,
    output btn_level
  );
endinterface

// File: rtl/debounce_toggle_gen.sv
// Push-button front end for a toggle flip-flop: 2-FF synchronizer, debounce FSM,
// one-cycle T_out pulse per accepted press. Optional auto-repeat: AUTO_REPEAT_EN.
module debounce_toggle_gen #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                 Clk,
  input  logic                 rst,
  debounce_toggle_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    PRESSED   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > (2 ** CNT_W) ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > (2 ** CNT_W)) begin : g_bad_params
    $error("debounce_toggle_gen: DB_CYCLES/REPEAT_CYCLES out of range for CNT_W");
  end

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             t_out_q, t_out_d;
  logic             btn_level_q, btn_level_d;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Synchronizer stage: only s2_q is ever seen by the FSM.
  always_comb begin
    s1_d = bus.btn_in;
    s2_d = s1_q;
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    t_out_d  = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d  = WAIT_HIGH;
          db_cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
          t_out_d  = 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else begin
          db_cnt_d = cnt_inc(db_cnt_q);
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d  = WAIT_LOW;
          db_cnt_d = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          t_out_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = cnt_inc(rep_cnt_q);
        end
`endif
      end
      WAIT_LOW: begin
        // A return to high here is release bounce: back to PRESSED, no pulse.
        if (s2_q) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
`ifdef AUTO_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = cnt_inc(db_cnt_q);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
    btn_level_d = (state_d == PRESSED) || (state_d == WAIT_LOW);
  end

  // Register stage: every flop is control, so all of them take the async reset.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      t_out_q     <= 1'b0;
      btn_level_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      t_out_q     <= t_out_d;
      btn_level_q <= btn_level_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign bus.T_out     = t_out_q;
  assign bus.btn_level = btn_level_q;

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// Directed bench for debounce_toggle_gen with a downstream TFF model; expected
// pulse edges are counted from the first edge sampling btn_in=1.
module tb_debounce_toggle_gen;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic Clk;
  logic rst;
  logic tff_q;
  int   errors;
  int   checks;

  logic t_tr [0:63];
  logic l_tr [0:63];
  logic q_tr [0:63];

  debounce_toggle_gen_if bus ();

  debounce_toggle_gen #(
    .DB_CYCLES    (4),
    .REPEAT_CYCLES(8),
    .CNT_W        (8)
  ) dut (
    .Clk(Clk),
    .rst(rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Downstream toggle flip-flop fed by T_out.
  always @(posedge Clk or negedge rst) begin
    if (!rst) tff_q <= 1'b0;
    else if (bus.T_out) tff_q <= ~tff_q;
  end

  task automatic run(input int n, input logic b, input int base);
    for (int i = 0; i < n; i++) begin
      bus.btn_in = b;
      @(posedge Clk);
      #1;
      t_tr[base+i] = bus.T_out;
      l_tr[base+i] = bus.btn_level;
      q_tr[base+i] = tff_q;
    end
  endtask

  task automatic reset_dut();
    bus.btn_in = 1'b0;
    rst = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.btn_in = i[0];
      @(posedge Clk); #1;
      checks++;
      if (bus.T_out !== 1'b0 || bus.btn_level !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got T_out=%b btn_level=%b, expected 0/0", i, bus.T_out, bus.btn_level);
      end
    end
    bus.btn_in = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      checks++;
      if (bus.T_out !== 1'b0 || bus.btn_level !== 1'b0) begin
        errors++;
        $display("FAIL reset_release[%0d]: got T_out=%b btn_level=%b, expected 0/0", i, bus.T_out, bus.btn_level);
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses;
    logic et, el;
    reset_dut();
    run(20, 1'b1, 0);
    run(20, 1'b0, 20);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      et = (i == 6) || (AR && i == 14);
      el = (i >= 6) && (i < 26);
      if (t_tr[i] === 1'b1) pulses++;
      checks++;
      if (t_tr[i] !== et || l_tr[i] !== el) begin
        errors++;
        $display("FAIL clean_press[%0d]: got T_out=%b btn_level=%b, expected %b/%b", i, t_tr[i], l_tr[i], et, el);
      end
    end
    checks++;
    if (pulses != (AR ? 2 : 1)) begin
      errors++;
      $display("FAIL clean_press_count: got %0d pulses, expected %0d", pulses, (AR ? 2 : 1));
    end
  endtask

  task automatic test_glitch();
    reset_dut();
    run(3, 1'b1, 0);
    run(12, 1'b0, 3);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (t_tr[i] !== 1'b0 || l_tr[i] !== 1'b0) begin
        errors++;
        $display("FAIL glitch[%0d]: got T_out=%b btn_level=%b, expected 0/0", i, t_tr[i], l_tr[i]);
      end
    end
    // A fresh press must take the full debounce from IDLE.
    run(10, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (t_tr[i] !== (i == 6) || l_tr[i] !== (i >= 6)) begin
        errors++;
        $display("FAIL glitch_repress[%0d]: got T_out=%b btn_level=%b, expected %b/%b", i, t_tr[i], l_tr[i], (i == 6), (i >= 6));
      end
    end
  endtask

  task automatic test_release_bounce();
    reset_dut();
    run(10, 1'b1, 0);
    checks++;
    if (l_tr[9] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_pressed: got btn_level=%b, expected 1", l_tr[9]);
    end
    run(2, 1'b0, 0);
    run(8, 1'b1, 2);
    run(10, 1'b0, 10);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (t_tr[i] !== 1'b0 || l_tr[i] !== (i < 16)) begin
        errors++;
        $display("FAIL release_bounce[%0d]: got T_out=%b btn_level=%b, expected 0/%b", i, t_tr[i], l_tr[i], (i < 16));
      end
    end
    run(10, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (t_tr[i] !== (i == 6)) begin
        errors++;
        $display("FAIL bounce_repress[%0d]: got T_out=%b, expected %b", i, t_tr[i], (i == 6));
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    run(5, 1'b1, 0);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.T_out !== 1'b0 || bus.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_now: got T_out=%b btn_level=%b, expected 0/0", bus.T_out, bus.btn_level);
    end
    @(posedge Clk); #1;
    rst = 1'b1;
    run(12, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (t_tr[i] !== (i == 6) || l_tr[i] !== (i >= 6)) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got T_out=%b btn_level=%b, expected %b/%b", i, t_tr[i], l_tr[i], (i == 6), (i >= 6));
      end
    end
    // Reset while pressed: level must drop asynchronously.
    rst = 1'b0;
    #1;
    checks++;
    if (bus.btn_level !== 1'b0 || bus.T_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_pressed_now: got T_out=%b btn_level=%b, expected 0/0", bus.T_out, bus.btn_level);
    end
    @(posedge Clk); #1;
    rst = 1'b1;
    run(8, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (t_tr[i] !== (i == 6)) begin
        errors++;
        $display("FAIL held_through_reset[%0d]: got T_out=%b, expected %b", i, t_tr[i], (i == 6));
      end
    end
  endtask

  task automatic test_tff_chain();
    logic et;
    logic par;
    reset_dut();
    run(30, 1'b1, 0);
    run(10, 1'b0, 30);
    par = 1'b0;
    for (int i = 0; i < 40; i++) begin
      et = (i == 6) || (AR && (i == 14 || i == 22 || i == 30));
      checks++;
      if (t_tr[i] !== et || q_tr[i] !== par) begin
        errors++;
        $display("FAIL tff_chain[%0d]: got T_out=%b Q=%b, expected %b/%b", i, t_tr[i], q_tr[i], et, par);
      end
      if (et) par = ~par;
    end
    checks++;
    if (tff_q !== (AR ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL tff_final: got Q=%b, expected %b", tff_q, (AR ? 1'b0 : 1'b1));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.btn_in = 1'b0;
    rst = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_reset_mid();
    test_tff_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
